// File: rtl/rca_accum.sv
// Accumulates operands through an external ripple-carry adder, sticky carry flag, 8-bit saturating count; RCA_ACCUM_SATURATE_EN clamps acc on carry.
// Latency: one cycle per operand; result valid the cycle after the operand flagged last.
// Backpressure: input stalls (PortIn_ready=0) while a result waits for PortOut_ready.

module rca_accum #(
    parameter int SIZE = 4
) (
    input  logic            PortClk,
    input  logic            PortRst_n,
    input  logic            PortIn_valid,
    output logic            PortIn_ready,
    input  logic [SIZE-1:0] PortIn_data,
    input  logic            PortIn_cin,
    input  logic            PortIn_last,
    output logic [SIZE-1:0] PortAdd_A,
    output logic [SIZE-1:0] PortAdd_B,
    output logic            PortAdd_Cin,
    input  logic [SIZE-1:0] PortAdd_S,
    input  logic            PortAdd_Cout,
    output logic            PortOut_valid,
    input  logic            PortOut_ready,
    output logic [SIZE-1:0] PortOut_sum,
    output logic            PortOut_ovf,
    output logic [7:0]      PortOut_cnt
);

    localparam logic [0:0] ST_ACC = 1'b0;
    localparam logic [0:0] ST_OUT = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [SIZE-1:0] acc_q, acc_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            accept;
    logic [SIZE-1:0] add_res;

    assign PortAdd_A   = acc_q;
    assign PortAdd_B   = PortIn_data;
    assign PortAdd_Cin = PortIn_cin;

    assign PortIn_ready  = (state_q == ST_ACC);
    assign PortOut_valid = (state_q == ST_OUT);
    assign PortOut_sum   = acc_q;
    assign PortOut_ovf   = ovf_q;
    assign PortOut_cnt   = cnt_q;

    assign accept = PortIn_valid && PortIn_ready;

`ifdef RCA_ACCUM_SATURATE_EN
    // A carry out means the true sum exceeded the range, so clamp to the maximum.
    assign add_res = PortAdd_Cout ? {SIZE{1'b1}} : PortAdd_S;
`else
    assign add_res = PortAdd_S;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        if (state_q == ST_ACC) begin
            if (accept) begin
                acc_d = add_res;
                ovf_d = ovf_q | PortAdd_Cout;
                cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                if (PortIn_last) begin
                    state_d = ST_OUT;
                end
            end
        end else begin
            if (PortOut_ready) begin
                state_d = ST_ACC;
                acc_d   = '0;
                ovf_d   = 1'b0;
                cnt_d   = 8'd0;
            end
        end
    end

    always_ff @(posedge PortClk) begin
        if (!PortRst_n) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// One-bit full adder cell used to build the external ripple-carry adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// N-bit ripple-carry adder: carry chains from bit 0 upward through full_adder cells.
module FAnbit_RCA #(
    parameter int N = 4
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] S,
    output logic         Cout
);
    logic [N:0] c;

    assign c[0] = Cin;
    assign Cout = c[N];

    for (genvar i = 0; i < N; i++) begin : g_bit
        full_adder u_fa (
            .a  (A[i]),
            .b  (B[i]),
            .ci (c[i]),
            .s  (S[i]),
            .co (c[i+1])
        );
    end
endmodule

// File: tb/tb_rca_accum.sv
// Directed bench for rca_accum (SIZE=4) wired to FAnbit_RCA; inputs driven and outputs sampled on the falling edge.
`timescale 1ns/1ps

module tb_rca_accum;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, in_cin, in_last;
    logic [3:0] in_data;
    logic [3:0] add_a, add_b, add_s;
    logic       add_cin, add_cout;
    logic       out_valid, out_ready, out_ovf;
    logic [3:0] out_sum;
    logic [7:0] out_cnt;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rca_accum #(.SIZE(4)) u_dut (
        .PortClk       (clk),
        .PortRst_n     (rst_n),
        .PortIn_valid  (in_valid),
        .PortIn_ready  (in_ready),
        .PortIn_data   (in_data),
        .PortIn_cin    (in_cin),
        .PortIn_last   (in_last),
        .PortAdd_A     (add_a),
        .PortAdd_B     (add_b),
        .PortAdd_Cin   (add_cin),
        .PortAdd_S     (add_s),
        .PortAdd_Cout  (add_cout),
        .PortOut_valid (out_valid),
        .PortOut_ready (out_ready),
        .PortOut_sum   (out_sum),
        .PortOut_ovf   (out_ovf),
        .PortOut_cnt   (out_cnt)
    );

    FAnbit_RCA #(.N(4)) u_rca (
        .A    (add_a),
        .B    (add_b),
        .Cin  (add_cin),
        .S    (add_s),
        .Cout (add_cout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one operand for one cycle; it is accepted on the following rising edge.
    task automatic put(input logic [3:0] d, input logic c, input logic l);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_cin   = c;
        in_last  = l;
        chk("in_ready", {31'd0, in_ready}, 32'd1);
        chk("add_b", {28'd0, add_b}, {28'd0, d});
        chk("add_cin", {31'd0, add_cin}, {31'd0, c});
    endtask

    // Expect the result the cycle after the last operand, take it, and confirm return to ACC.
    task automatic take(input string tag, input logic [3:0] s, input logic o, input logic [7:0] n);
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_sum"}, {28'd0, out_sum}, {28'd0, s});
        chk({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, o});
        chk({tag, "_cnt"}, {24'd0, out_cnt}, {24'd0, n});
        @(negedge clk);
        chk({tag, "_vld_off"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_acc_clr"}, {28'd0, add_a}, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        in_cin    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {28'd0, out_sum}, 32'd0);
        chk("rst_ovf", {31'd0, out_ovf}, 32'd0);
        chk("rst_cnt", {24'd0, out_cnt}, 32'd0);
        rst_n = 1'b1;

        // 3 + 5 + 7 = 15, no carry.
        put(4'd3, 1'b0, 1'b0);
        put(4'd5, 1'b0, 1'b0);
        @(negedge clk);
        chk("s1_add_a_mid", {28'd0, add_a}, 32'd8);
        in_data = 4'd7; in_last = 1'b1;
        take("s1", 4'd15, 1'b0, 8'd3);

        // 9 + 9 = 18: wraps to 2, or clamps to 15 when saturating.
        put(4'd9, 1'b0, 1'b0);
        put(4'd9, 1'b0, 1'b1);
`ifdef RCA_ACCUM_SATURATE_EN
        take("s2", 4'd15, 1'b1, 8'd2);
`else
        take("s2", 4'd2, 1'b1, 8'd2);
`endif

        // 7 with carry-in = 8.
        put(4'd7, 1'b1, 1'b1);
        take("s3", 4'd8, 1'b0, 8'd1);

        // Result held with PortOut_ready=0 while the source keeps offering data.
        out_ready = 1'b0;
        put(4'd1, 1'b0, 1'b0);
        put(4'd2, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 4'd5; in_last = 1'b1;
            chk("s4_hold_rdy", {31'd0, in_ready}, 32'd0);
            chk("s4_hold_vld", {31'd0, out_valid}, 32'd1);
            chk("s4_hold_sum", {28'd0, out_sum}, 32'd3);
            chk("s4_hold_cnt", {24'd0, out_cnt}, 32'd2);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("s4_back_acc", {31'd0, in_ready}, 32'd1);
        chk("s4_acc_zero", {28'd0, add_a}, 32'd0);
        chk("s4_cnt_zero", {24'd0, out_cnt}, 32'd0);
        put(4'd1, 1'b0, 1'b1);
        take("s4b", 4'd1, 1'b0, 8'd1);

        // Reset mid-sum, asserted together with a valid operand.
        put(4'd4, 1'b0, 1'b0);
        put(4'd4, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        in_last = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("s5_acc_zero", {28'd0, add_a}, 32'd0);
        chk("s5_cnt_zero", {24'd0, out_cnt}, 32'd0);
        chk("s5_out_vld", {31'd0, out_valid}, 32'd0);
        put(4'd1, 1'b0, 1'b1);
        take("s5", 4'd1, 1'b0, 8'd1);

        // 256 zero operands: count saturates at 255.
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 4'd0; in_cin = 1'b0;
            in_last  = (i == 255);
        end
        take("s6", 4'd0, 1'b0, 8'd255);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
